// File: rtl/pipelined_bitonic_sort_engine_if.sv
// Handshake bundle for the pipelined bitonic sort engine.
// The engine connects through the slave modport; the producer/consumer side uses master.
// out_idx exists only when BITONIC_SORT_IDX_EN is defined.
interface pipelined_bitonic_sort_engine_if #(
  parameter int DATA_W = 7,
  parameter int LOG2_N = 3
);
  localparam int N = 1 << LOG2_N;

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_desc;
  logic [N*DATA_W-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [N*DATA_W-1:0]   out_data;
`ifdef BITONIC_SORT_IDX_EN
  logic [N*LOG2_N-1:0]   out_idx;

  modport master (
    output in_valid, in_desc, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );

  modport slave (
    input  in_valid, in_desc, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );
`else
  modport master (
    output in_valid, in_desc, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_desc, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
`endif
endinterface

// File: rtl/pipelined_bitonic_sort_engine.sv
// Fully pipelined bitonic sorter: one vector of 2**LOG2_N keys per cycle,
// one register stage after every merge column, global stall from out_ready.
// Optional feature macro: BITONIC_SORT_IDX_EN -- each element carries its
// original lane as a tag, ties break to the lower lane, out_idx reports it.
module pipelined_bitonic_sort_engine #(
  parameter int DATA_W = 7,
  parameter int LOG2_N = 3,
  parameter int SIGNED = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  pipelined_bitonic_sort_engine_if.slave bus
);
  localparam int N = 1 << LOG2_N;
  localparam int S = LOG2_N * (LOG2_N + 1) / 2;
`ifdef BITONIC_SORT_IDX_EN
  localparam int TAG_W = LOG2_N;
`else
  localparam int TAG_W = 0;
`endif
  // Element = {data, tag}; with the tag absent it is just the data.
  localparam int EW = DATA_W + TAG_W;
  // Flipping the sign bit turns a two's complement compare into an unsigned one.
  localparam logic SIGN_FLIP = (SIGNED != 0);

  // Merge phase (block size 2**k) that owns column col.
  function automatic int merge_k(input int col);
    int k;
    k = 1;
    for (int m = 1; m <= 5; m++) begin
      if (col >= m * (m + 1) / 2) k = m + 1;
    end
    return k;
  endfunction

  logic adv;

  // Whole pipeline moves together; an empty output slot never blocks.
  assign adv          = bus.out_ready | ~g_stage[S-1].valid_reg;
  assign bus.in_ready = adv;
  assign bus.out_valid = g_stage[S-1].valid_reg;

  for (genvar gs = 0; gs < S; gs++) begin : g_stage
    localparam int GK = merge_k(gs);
    localparam int GJ = GK - 1 - (gs - GK * (GK - 1) / 2);

    logic [EW-1:0] lane_in  [N];
    logic [EW-1:0] lane_out [N];
    logic          desc_in;
    logic          valid_in;
    logic [EW-1:0] elem_reg [N];
    logic          desc_reg;
    logic          valid_reg;

    if (gs == 0) begin : g_head
      assign desc_in  = bus.in_desc;
      assign valid_in = bus.in_valid;
      for (genvar gi = 0; gi < N; gi++) begin : g_lane
`ifdef BITONIC_SORT_IDX_EN
        assign lane_in[gi] = {bus.in_data[gi*DATA_W +: DATA_W], TAG_W'(gi)};
`else
        assign lane_in[gi] = bus.in_data[gi*DATA_W +: DATA_W];
`endif
      end
    end else begin : g_body
      assign desc_in  = g_stage[gs-1].desc_reg;
      assign valid_in = g_stage[gs-1].valid_reg;
      for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign lane_in[gi] = g_stage[gs-1].elem_reg[gi];
      end
    end

    // Compare-exchange column: lanes gi and gi + 2**GJ, direction set by merge block.
    for (genvar gi = 0; gi < N; gi++) begin : g_cx
      if (((gi >> GJ) & 1) == 0) begin : g_pair
        localparam int   P        = gi + (1 << GJ);
        localparam logic COL_DESC = (((gi >> GK) & 1) != 0);

        logic [EW-1:0] key_lo;
        logic [EW-1:0] key_hi;
        logic          swap;

        // Build order-preserving unsigned keys; in descending vectors the tag is
        // inverted so that ties still come out lower lane first.
        always_comb begin
          key_lo = lane_in[gi];
          key_hi = lane_in[P];
          key_lo[EW-1] = lane_in[gi][EW-1] ^ SIGN_FLIP;
          key_hi[EW-1] = lane_in[P][EW-1] ^ SIGN_FLIP;
`ifdef BITONIC_SORT_IDX_EN
          key_lo[TAG_W-1:0] = lane_in[gi][TAG_W-1:0] ^ {TAG_W{desc_in}};
          key_hi[TAG_W-1:0] = lane_in[P][TAG_W-1:0] ^ {TAG_W{desc_in}};
`endif
        end

        // Strict compare: equal keys stay where they are.
        assign swap = (COL_DESC ^ desc_in) ? (key_lo < key_hi) : (key_lo > key_hi);
        assign lane_out[gi] = swap ? lane_in[P]  : lane_in[gi];
        assign lane_out[P]  = swap ? lane_in[gi] : lane_in[P];
      end
    end

    // Stage register; reset clears valid bits and the visible output stage.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= 1'b0;
        if (gs == S - 1) begin
          for (int e = 0; e < N; e++) elem_reg[e] <= '0;
        end
      end else if (adv) begin
        valid_reg <= valid_in;
        desc_reg  <= desc_in;
        for (int e = 0; e < N; e++) elem_reg[e] <= lane_out[e];
      end
    end
  end

  // Unpack the last stage onto the output bus.
  always_comb begin
    bus.out_data = '0;
    for (int e = 0; e < N; e++) begin
      bus.out_data[e*DATA_W +: DATA_W] = g_stage[S-1].elem_reg[e][EW-1 -: DATA_W];
    end
  end

`ifdef BITONIC_SORT_IDX_EN
  // Original lane of each output element.
  always_comb begin
    bus.out_idx = '0;
    for (int e = 0; e < N; e++) begin
      bus.out_idx[e*LOG2_N +: LOG2_N] = g_stage[S-1].elem_reg[e][TAG_W-1:0];
    end
  end
`endif
endmodule

// File: tb/tb_pipelined_bitonic_sort_engine.sv
// Directed bench for pipelined_bitonic_sort_engine (N=8, DATA_W=7).
// Signed and unsigned instances side by side; one line per transaction.
module tb_pipelined_bitonic_sort_engine;
  localparam int DATA_W = 7;
  localparam int LOG2_N = 3;
  localparam int S      = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipelined_bitonic_sort_engine_if #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) bus_s ();
  pipelined_bitonic_sort_engine_if #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) bus_u ();

  pipelined_bitonic_sort_engine #(.DATA_W(DATA_W), .LOG2_N(LOG2_N), .SIGNED(1)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  pipelined_bitonic_sort_engine #(.DATA_W(DATA_W), .LOG2_N(LOG2_N), .SIGNED(0)) dut_u (
    .clk (clk),
    .rst (rst),
    .bus (bus_u)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] pack8(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
    return {7'(a7), 7'(a6), 7'(a5), 7'(a4), 7'(a3), 7'(a2), 7'(a1), 7'(a0)};
  endfunction

  function automatic logic [23:0] pack_idx(input int a0, input int a1, input int a2, input int a3,
                                           input int a4, input int a5, input int a6, input int a7);
    return {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  // Reference sort used for the random streams.
  function automatic logic [55:0] ref_sort(input logic [55:0] d, input logic desc, input bit sgn);
    int v [8];
    int t;
    logic [55:0] r;
    for (int i = 0; i < 8; i++) begin
      v[i] = sgn ? int'($signed(d[i*7 +: 7])) : int'(d[i*7 +: 7]);
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 7 - i; j++) begin
        if (desc ? (v[j] < v[j+1]) : (v[j] > v[j+1])) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
      end
    end
    for (int i = 0; i < 8; i++) r[i*7 +: 7] = 7'(v[i]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One vector into both instances, checking exact latency S.
  task automatic run_single(input string tag, input logic [55:0] d, input logic desc,
                            input logic [55:0] exp_s, input logic [55:0] exp_u,
                            input logic [23:0] exp_idx);
    bus_s.in_data = d; bus_s.in_desc = desc; bus_s.in_valid = 1'b1;
    bus_u.in_data = d; bus_u.in_desc = desc; bus_u.in_valid = 1'b1;
    check({tag, " in_ready"}, 64'(bus_s.in_ready), 64'd1);
    tick();
    bus_s.in_valid = 1'b0;
    bus_u.in_valid = 1'b0;
    for (int k = 1; k < S; k++) begin
      check({tag, " early valid"}, 64'(bus_s.out_valid), 64'd0);
      tick();
    end
    check({tag, " valid"}, 64'(bus_s.out_valid), 64'd1);
    check({tag, " data signed"}, 64'(bus_s.out_data), 64'(exp_s));
    check({tag, " valid unsigned"}, 64'(bus_u.out_valid), 64'd1);
    check({tag, " data unsigned"}, 64'(bus_u.out_data), 64'(exp_u));
`ifdef BITONIC_SORT_IDX_EN
    check({tag, " idx"}, 64'(bus_s.out_idx), 64'(exp_idx));
`endif
    $display("%s: in=%h desc=%0d signed_out=%h unsigned_out=%h idx_exp=%h",
             tag, d, desc, bus_s.out_data, bus_u.out_data, exp_idx);
    tick();
    check({tag, " valid one cycle"}, 64'(bus_s.out_valid), 64'd0);
  endtask

  // Stream n random vectors alternating asc/desc; out_ready low for sl cycles from cycle ss.
  task automatic run_stream(input string tag, input int n, input int ss, input int sl);
    logic [55:0] exp_q [$];
    logic [55:0] held;
    logic [55:0] d;
    logic [55:0] e;
    int sent;
    int got;
    int first_c;
    int last_c;
    bit stall;
    sent = 0; got = 0; first_c = -1; last_c = -1; held = '0;
    for (int c = 0; c < 200 && got < n; c++) begin
      stall = (c >= ss) && (c < ss + sl);
      bus_s.out_ready = ~stall;
      #1;
      bus_s.in_valid = 1'b0;
      if (sent < n) begin
        check({tag, " in_ready"}, 64'(bus_s.in_ready), stall ? 64'd0 : 64'd1);
        if (bus_s.in_ready) begin
          d = 56'({$urandom, $urandom});
          bus_s.in_data  = d;
          bus_s.in_desc  = sent[0];
          bus_s.in_valid = 1'b1;
          exp_q.push_back(ref_sort(d, sent[0], 1'b1));
          sent++;
        end
      end
      if (bus_s.out_valid) begin
        if (bus_s.out_ready) begin
          if (exp_q.size() == 0) begin
            check({tag, " unexpected output"}, 64'(bus_s.out_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check({tag, " data"}, 64'(bus_s.out_data), 64'(e));
            $display("%s: cycle=%0d out=%h exp=%h", tag, c, bus_s.out_data, e);
          end
          got++;
          if (first_c < 0) first_c = c;
          last_c = c;
        end else if (c > ss) begin
          check({tag, " held data"}, 64'(bus_s.out_data), 64'(held));
        end
        held = bus_s.out_data;
      end
      tick();
    end
    bus_s.in_valid  = 1'b0;
    bus_s.out_ready = 1'b1;
    check({tag, " count"}, 64'(got), 64'(n));
    check({tag, " span"}, 64'(last_c - first_c), 64'(n - 1 + sl));
  endtask

  initial begin
    int emitted;
    logic [55:0] v1;
    logic [55:0] v3;
    logic [55:0] v6;

    bus_s.in_valid = 1'b0; bus_s.in_desc = 1'b0; bus_s.in_data = '0; bus_s.out_ready = 1'b1;
    bus_u.in_valid = 1'b0; bus_u.in_desc = 1'b0; bus_u.in_data = '0; bus_u.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset out_valid", 64'(bus_s.out_valid), 64'd0);
    check("reset out_data", 64'(bus_s.out_data), 64'd0);
    check("reset in_ready", 64'(bus_s.in_ready), 64'd1);
`ifdef BITONIC_SORT_IDX_EN
    check("reset out_idx", 64'(bus_s.out_idx), 64'd0);
`endif
    $display("reset: out_valid=%0d out_data=%h in_ready=%0d", bus_s.out_valid, bus_s.out_data, bus_s.in_ready);

    v1 = pack8(3, -1, 7, 0, -64, 63, 2, 2);
    run_single("t1 asc", v1, 1'b0,
               pack8(-64, -1, 0, 2, 2, 3, 7, 63),
               pack8(0, 2, 2, 3, 7, 63, 64, 127),
               pack_idx(4, 1, 3, 6, 7, 0, 2, 5));
    run_single("t2 desc", v1, 1'b1,
               pack8(63, 7, 3, 2, 2, 0, -1, -64),
               pack8(127, 64, 63, 7, 3, 2, 2, 0),
               pack_idx(5, 2, 0, 6, 7, 3, 1, 4));

    v3 = pack8(8'h7F, 8'h00, 8'h40, 8'h01, 8'h10, 8'h05, 8'h3F, 8'h02);
    run_single("t3 sign", v3, 1'b0,
               pack8(8'h40, 8'h7F, 8'h00, 8'h01, 8'h02, 8'h05, 8'h10, 8'h3F),
               pack8(8'h00, 8'h01, 8'h02, 8'h05, 8'h10, 8'h3F, 8'h40, 8'h7F),
               pack_idx(2, 0, 1, 3, 7, 5, 4, 6));

    run_stream("t4 stream", 20, 1000, 0);
    run_stream("t5 stall", 10, 8, 3);

    // Four vectors in flight, then reset with a vector offered during it.
    for (int k = 0; k < 4; k++) begin
      bus_s.in_data  = pack8(k, -k, 5, 9, -3, 1, 0, 60);
      bus_s.in_desc  = 1'(k);
      bus_s.in_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    bus_s.in_data = pack8(1, 2, 3, 4, 5, 6, 7, 8);
    tick();
    rst = 1'b0;
    bus_s.in_valid = 1'b0;
    check("t6 reset out_valid", 64'(bus_s.out_valid), 64'd0);
    check("t6 reset out_data", 64'(bus_s.out_data), 64'd0);
    check("t6 reset in_ready", 64'(bus_s.in_ready), 64'd1);
    emitted = 0;
    for (int k = 0; k < S + 2; k++) begin
      if (bus_s.out_valid) emitted++;
      tick();
    end
    check("t6 flushed emitted", 64'(emitted), 64'd0);
    $display("t6 reset: emitted=%0d", emitted);

    v6 = pack8(10, -5, 0, -5, 20, 1, -30, 8);
    run_single("t6 after reset", v6, 1'b0,
               pack8(-30, -5, -5, 0, 1, 8, 10, 20),
               pack8(0, 1, 8, 10, 20, -30, -5, -5),
               pack_idx(6, 1, 3, 2, 5, 7, 0, 4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
